// File: rtl/sb_arbiter_pkg.sv
// Shared encodings and helpers for the system-bus arbiter and its load/store aligner.
package sb_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] ZERO32 = 32'h0000_0000;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

  // Everything needed to format the read data one cycle after the grant.
  typedef struct packed {
    tag_e       tag;
    logic [1:0] lane;
    logic [1:0] size;
    logic       un_sign;
  } resp_tag_t;

  localparam resp_tag_t RESP_NONE = '{tag: TAG_NONE, lane: 2'b00, size: 2'b00, un_sign: 1'b0};

  function automatic logic [31:0] extend_load(input logic [15:0] val, input logic is_half,
                                              input logic un_sign);
    logic fill;
    if (is_half) begin
      fill = val[15] & ~un_sign;
      return {{16{fill}}, val};
    end
    fill = val[7] & ~un_sign;
    return {{24{fill}}, val[7:0]};
  endfunction

endpackage

// File: rtl/sb_arbiter_if.sv
// Core-side request/response signals and RAM-side strobes of the shared memory port.
interface sb_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_re;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_size;
  logic              d_un_sign;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_misalign;

  logic              if_stall;
  logic              d_stall;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // master: the core plus the RAM; slave: the arbiter sitting between them.
  modport master (
    output if_req, if_addr, d_re, d_we, d_addr, d_size, d_un_sign, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_misalign,
    input  if_stall, d_stall, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_re, d_we, d_addr, d_size, d_un_sign, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_misalign,
    output if_stall, d_stall, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sb_lsu_align.sv
// Combinational store lane replication / byte enables, load lane select / extension,
// and misalignment detection for the data port.
module sb_lsu_align
  import sb_arbiter_pkg::*;
(
  input  logic [1:0]  i_req_lane,
  input  logic [1:0]  i_req_size,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  output logic        o_misalign,

  input  logic [1:0]  i_ld_lane,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_un_sign,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_lane_byte [4];
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_byte[gi] = i_ld_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    o_misalign = 1'b0;
    o_st_be    = 4'b0000;
    o_st_wdata = ZERO32;
    case (i_req_size)
      SZ_B: begin
        o_st_be    = 4'b0001 << i_req_lane;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      SZ_H: begin
        o_misalign = i_req_lane[0];
        o_st_be    = 4'b0011 << i_req_lane;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      SZ_W: begin
        o_misalign = |i_req_lane;
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
      end
      default: o_misalign = 1'b1;
    endcase
  end

  // Halves are only ever granted on even lanes, so lane[1] alone picks the half.
  always_comb begin
    w_ld_byte = w_lane_byte[i_ld_lane];
    w_ld_half = i_ld_lane[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_size)
      SZ_B:    o_ld_data = extend_load({8'h00, w_ld_byte}, 1'b0, i_ld_un_sign);
      SZ_H:    o_ld_data = extend_load(w_ld_half, 1'b1, i_ld_un_sign);
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/sb_arbiter.sv
// Shares one single-port 1-cycle-latency RAM between instruction fetch and load/store,
// with data priority, a fetch anti-starvation counter and a registered response tag.
module sb_arbiter
  import sb_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  sb_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic        w_d_req;
  logic        w_d_store;
  logic        w_misalign;
  logic        w_force_if;
  logic        w_d_gnt;
  logic        w_if_gnt;
  logic [3:0]  r_starve;
  logic [3:0]  w_starve_next;
  resp_tag_t   r_tag;
  resp_tag_t   w_tag_next;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;
  logic        w_if_rvalid;
  logic        w_d_rvalid;
  logic        w_unused;

  // Fetch addresses are word aligned; their low bits carry no information.
  assign w_unused = &{1'b0, bus.if_addr[1:0]};

  sb_lsu_align u_align (
    .i_req_lane   (bus.d_addr[1:0]),
    .i_req_size   (bus.d_size),
    .i_st_wdata   (bus.d_wdata),
    .o_st_be      (w_st_be),
    .o_st_wdata   (w_st_wdata),
    .o_misalign   (w_misalign),
    .i_ld_lane    (r_tag.lane),
    .i_ld_size    (r_tag.size),
    .i_ld_un_sign (r_tag.un_sign),
    .i_ld_rdata   (bus.mem_rdata),
    .o_ld_data    (w_ld_data)
  );

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    w_d_req    = bus.d_re | bus.d_we;
    w_d_store  = bus.d_we;
    w_force_if = bus.if_req & (r_starve == STARVE_LIM);
    w_d_gnt    = ~rst & w_d_req & ~w_misalign & ~w_force_if;
    w_if_gnt   = ~rst & bus.if_req & ~w_d_gnt;
  end

  always_comb begin
    w_starve_next = r_starve;
    if (!bus.if_req || w_if_gnt) begin
      w_starve_next = 4'd0;
    end else if (r_starve < STARVE_LIM) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  always_comb begin
    w_tag_next = RESP_NONE;
    if (w_if_gnt) begin
      w_tag_next.tag = TAG_IF;
    end else if (w_d_gnt && !w_d_store) begin
      w_tag_next.tag     = TAG_D;
      w_tag_next.lane    = bus.d_addr[1:0];
      w_tag_next.size    = bus.d_size;
      w_tag_next.un_sign = bus.d_un_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= 4'd0;
      r_tag    <= RESP_NONE;
    end else begin
      r_starve <= w_starve_next;
      r_tag    <= w_tag_next;
    end
  end

  // A response still tagged during the reset cycle is dropped here.
  always_comb begin
    w_if_rvalid = ~rst & (r_tag.tag == TAG_IF);
    w_d_rvalid  = ~rst & (r_tag.tag == TAG_D);
  end

  always_comb begin
    bus.if_gnt     = w_if_gnt;
    bus.d_gnt      = w_d_gnt;
    bus.if_stall   = ~rst & bus.if_req & ~w_if_gnt;
    bus.d_stall    = ~rst & w_d_req & ~w_d_gnt & ~w_misalign;
    bus.d_misalign = ~rst & w_d_req & w_misalign;

    bus.mem_en    = w_if_gnt | w_d_gnt;
    bus.mem_we    = w_d_gnt & w_d_store;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = ZERO32;
    if (w_d_gnt) begin
      bus.mem_addr  = bus.d_addr[ADDR_W-1:2];
      bus.mem_be    = w_d_store ? w_st_be : 4'b1111;
      bus.mem_wdata = w_d_store ? w_st_wdata : ZERO32;
    end else if (w_if_gnt) begin
      bus.mem_addr = bus.if_addr[ADDR_W-1:2];
      bus.mem_be   = 4'b1111;
    end

    bus.if_rvalid = w_if_rvalid;
    bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : ZERO32;
    bus.d_rvalid  = w_d_rvalid;
    bus.d_rdata   = w_d_rvalid ? w_ld_data : ZERO32;
  end

  // Load and store together is a core bug; the request is served as a store.
  a_rw_exclusive : assert property (@(posedge clk) disable iff (rst) !(bus.d_re && bus.d_we));

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed bench for sb_arbiter: stimulus pushes expected responses, a monitor pops on rvalid.
`timescale 1ns/1ps
module tb_sb_arbiter;
  import sb_arbiter_pkg::*;

  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sb_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port RAM with one cycle read latency.
  logic [31:0] ram [0:1023];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        ram_q <= ram[bus.mem_addr[9:0]];
      end
    end
  end
  assign bus.mem_rdata = ram_q;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_rsp(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: any rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.if_rvalid || bus.d_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got if_rvalid=%b d_rvalid=%b, required no response",
                 bus.if_rvalid, bus.d_rvalid);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.d_rvalid !== mon_e.is_d || bus.if_rvalid !== !mon_e.is_d ||
            (mon_e.is_d ? bus.d_rdata : bus.if_rdata) !== mon_e.data) begin
          failures++;
          $display("FAIL rsp_data: got if_rvalid=%b d_rvalid=%b if_rdata=%h d_rdata=%h, required %s data %h",
                   bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata,
                   mon_e.is_d ? "D" : "IF", mon_e.data);
        end else begin
          $display("rsp %s data=%h", mon_e.is_d ? "D " : "IF", mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ia, input logic re, input logic we,
                       input logic [31:0] da, input logic [1:0] sz, input logic us,
                       input logic [31:0] wd);
    bus.if_req    = ifr;
    bus.if_addr   = ia;
    bus.d_re      = re;
    bus.d_we      = we;
    bus.d_addr    = da;
    bus.d_size    = sz;
    bus.d_un_sign = us;
    bus.d_wdata   = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input logic [31:0] a, input logic [1:0] sz, input logic us,
                          input logic [31:0] exp);
    drive(1'b0, 32'h0, 1'b1, 1'b0, a, sz, us, 32'h0);
    expect_rsp(1'b1, exp);
    @(negedge clk);
    $display("load  addr=%h size=%0d uns=%0d expect=%h", a, sz, us, exp);
    chk("ld_gnt", 32'(bus.d_gnt), 32'd1);
    chk("ld_we", 32'(bus.mem_we), 32'd0);
    chk("ld_be", 32'(bus.mem_be), 32'hF);
    chk("ld_addr", 32'(bus.mem_addr), a >> 2);
    next_cycle();
  endtask

  task automatic store_vec(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    drive(1'b0, 32'h0, 1'b0, 1'b1, a, sz, 1'b0, wd);
    @(negedge clk);
    $display("store addr=%h size=%0d wdata=%h expect be=%b lanes=%h", a, sz, wd, exp_be, exp_wdata);
    chk("st_gnt", 32'(bus.d_gnt), 32'd1);
    chk("st_we", 32'(bus.mem_we), 32'd1);
    chk("st_be", 32'(bus.mem_be), 32'(exp_be));
    chk("st_wdata", bus.mem_wdata, exp_wdata);
    chk("st_addr", 32'(bus.mem_addr), a >> 2);
    next_cycle();
  endtask

  task automatic mis_vec(input logic [31:0] a, input logic [1:0] sz, input logic ifr);
    drive(ifr, 32'h100, 1'b1, 1'b0, a, sz, 1'b0, 32'h0);
    if (ifr) expect_rsp(1'b0, 32'h0000_0013);
    @(negedge clk);
    $display("misaligned addr=%h size=%0d if_req=%0d", a, sz, ifr);
    chk("mis_pulse", 32'(bus.d_misalign), 32'd1);
    chk("mis_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("mis_d_stall", 32'(bus.d_stall), 32'd0);
    chk("mis_mem_en", 32'(bus.mem_en), 32'(ifr));
    chk("mis_if_gnt", 32'(bus.if_gnt), 32'(ifr));
    next_cycle();
  endtask

  // Loads every cycle with fetch pending: fetch loses four times, wins the fifth.
  task automatic starve_run(input int n, input int npush);
    logic exp_if;
    for (int i = 0; i < n; i++) begin
      exp_if = ((i % 5) == 4);
      drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, SZ_W, 1'b0, 32'h0);
      if (i < npush) expect_rsp(!exp_if, exp_if ? 32'h0000_0013 : 32'h80FF_7F01);
      @(negedge clk);
      $display("starve cycle=%0d expect %s grant", i, exp_if ? "IF" : "D");
      chk("starve_if_gnt", 32'(bus.if_gnt), 32'(exp_if));
      chk("starve_d_gnt", 32'(bus.d_gnt), 32'(!exp_if));
      chk("starve_if_stall", 32'(bus.if_stall), 32'(!exp_if));
      chk("starve_d_stall", 32'(bus.d_stall), 32'(exp_if));
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[10'h040] = 32'h0000_0013;
    ram[10'h080] = 32'h80FF_7F01;

    // Reset held with both ports requesting: everything stays quiet.
    rst = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, SZ_W, 1'b0, 32'h0);
    @(negedge clk);
    $display("reset hold");
    chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_if_stall", 32'(bus.if_stall), 32'd0);
    chk("rst_d_stall", 32'(bus.d_stall), 32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle();
    next_cycle();

    // Fetch stream.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
      expect_rsp(1'b0, 32'h0000_0013);
      @(negedge clk);
      $display("fetch addr=00000100 cycle=%0d", i);
      chk("fetch_gnt", 32'(bus.if_gnt), 32'd1);
      chk("fetch_stall", 32'(bus.if_stall), 32'd0);
      chk("fetch_mem_addr", 32'(bus.mem_addr), 32'h40);
      next_cycle();
    end

    // Back-to-back loads against word 0x80FF7F01.
    load_vec(32'h203, SZ_B, 1'b0, 32'hFFFF_FF80);
    load_vec(32'h203, SZ_B, 1'b1, 32'h0000_0080);
    load_vec(32'h202, SZ_H, 1'b0, 32'hFFFF_80FF);
    load_vec(32'h200, SZ_H, 1'b1, 32'h0000_7F01);
    load_vec(32'h201, SZ_B, 1'b0, 32'h0000_007F);
    load_vec(32'h202, SZ_B, 1'b0, 32'hFFFF_FFFF);
    load_vec(32'h200, SZ_W, 1'b0, 32'h80FF_7F01);

    // Stores, then read the words back.
    store_vec(32'h302, SZ_H, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store_vec(32'h301, SZ_B, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    store_vec(32'h304, SZ_W, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    load_vec(32'h300, SZ_W, 1'b0, 32'hBEEF_7800);
    load_vec(32'h304, SZ_W, 1'b0, 32'hCAFE_F00D);

    // Misaligned and reserved-size requests.
    mis_vec(32'h105, SZ_W, 1'b0);
    mis_vec(32'h201, SZ_H, 1'b0);
    mis_vec(32'h200, 2'b11, 1'b0);
    mis_vec(32'h106, SZ_W, 1'b1);
    idle();
    next_cycle();

    starve_run(10, 10);
    idle();
    next_cycle();

    // Fetch granted, reset on the next edge: its response must never appear.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
    @(negedge clk);
    $display("fetch then reset");
    chk("pre_rst_if_gnt", 32'(bus.if_gnt), 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("mid_rst_if_rdata", bus.if_rdata, 32'h0);
    chk("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    next_cycle();

    // Build up the starve counter, reset, and confirm it restarted from zero.
    starve_run(4, 3);
    rst = 1'b1;
    @(negedge clk);
    $display("reset with starve counter at limit");
    chk("rst2_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rst2_if_gnt", 32'(bus.if_gnt), 32'd0);
    next_cycle();
    rst = 1'b0;
    starve_run(5, 5);
    idle();
    next_cycle();
    next_cycle();

    chk("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_arbiter.md
Name: sb_arbiter

Overview:
- Shares one single-port, 1-cycle-latency synchronous RAM between the core's instruction-fetch port and its load/store port.
- Sits between the core top-level (pc fetch address, executrol memory outputs) and the system-bus memory.
- Arbitrates requests, aligns and byte-enables stores, extracts and sign-extends loads, and raises per-port stalls.

Parameters:
- ADDR_W, 32, byte-address width of both ports and the RAM.
- STARVE_MAX, 4, consecutive fetch losses (1..15) before fetch is forced to win one cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address; word aligned.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid; one cycle after if_gnt.
- if_rdata  out  32  fetched instruction.
- d_re  in  1  load request.
- d_we  in  1  store request; d_re and d_we both high is illegal.
- d_addr  in  ADDR_W  load/store byte address.
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- d_un_sign  in  1  1 = zero-extend load, 0 = sign-extend.
- d_wdata  in  32  store data, right-justified.
- d_gnt  out  1  load/store accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  extended load data.
- d_misalign  out  1  one-cycle pulse on misaligned or reserved-size access.
- if_stall  out  1  if_req & ~if_gnt.
- d_stall  out  1  (d_re|d_we) & ~d_gnt & ~misaligned.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write.
- mem_be  out  4  RAM byte enables.
- mem_addr  out  ADDR_W-2  RAM word address.
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- Reset values: all outputs 0; starve counter 0; response tag NONE.
- Grant rule each cycle:
  - Data wins over fetch.
  - Exception: starve_cnt == STARVE_MAX and if_req high gives fetch the grant.
- Starve counter:
  - Increments when if_req is high, fetch loses, and the counter is below STARVE_MAX.
  - Clears on any if_gnt, or when if_req is low.
- Grants are combinational from the current-cycle inputs. At most one grant per cycle.
- Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0, size 11):
  - No grant, no mem_en.
  - d_misalign pulses the same cycle.
  - d_stall stays low; the requester is not held.
- Store, on d_gnt & d_we:
  - mem_we=1.
  - mem_be: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
  - mem_wdata = d_wdata replicated per lane (byte x4, half x2).
  - No d_rvalid follows.
- Load or fetch, on grant:
  - mem_we=0, mem_be=1111.
  - Response tag register records IF or D, plus a[1:0], size and un_sign for D.
- Response cycle (tag != NONE):
  - Tag IF: if_rvalid=1, if_rdata = mem_rdata.
  - Tag D: d_rvalid=1; select lane by the stored a[1:0]; zero- or sign-extend by the stored size and un_sign.
  - The tag is overwritten by the new grant's tag (or NONE) every cycle. Back-to-back grants therefore give back-to-back rvalids, with no bubble.
- Response data is combinational from mem_rdata and registered tag fields; rdata outputs are 0 when their rvalid is low.
- Reset mid-operation: a pending response is dropped; no rvalid is issued after the reset cycle.
- Simultaneous d_re & d_we: treated as a store; an assertion flags it in simulation.

Decomposition:
- Shared package:
  - Size encodings: SZ_B, SZ_H, SZ_W.
  - Tag encodings: TAG_NONE, TAG_IF, TAG_D.
  - 32-bit zero constant.
- One sub-module, sb_lsu_align:
  - Combinational store lane replication and byte-enable generation.
  - Load lane select and extension.
  - Misalign detection.
- The arbiter, starve counter and tag register stay in sb_arbiter.

Test Plan:
- Fetch only, if_addr 0x100 every cycle, mem returns 0x00000013 → if_gnt high each cycle; if_rvalid 1 cycle later; if_rdata=0x00000013; if_stall low.
- Load byte, signed, addr 0x203, mem word 0x80FF7F01 → mem_be=1111; d_rdata=0xFFFFFF80. Same access with d_un_sign=1 → 0x00000080.
- Store half, addr 0x302, d_wdata=0x0000BEEF → mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0xC0; no d_rvalid.
- Continuous loads plus if_req, STARVE_MAX=4 → fetch stalls 4 cycles, wins on the 5th with d_stall high that cycle, then the pattern repeats.
- Word load at addr 0x105 → d_misalign pulse, mem_en=0, d_gnt=0, d_stall=0.
- Fetch granted, rst asserted on the next edge → if_rvalid stays 0, all outputs 0, starve counter 0.
